// File: rtl/cont4bits_down_timer.sv
// Loadable down-counter/timer with continuous (auto-reload) and one-shot modes.
// Ports: clk, reseta_n (sync, active-low), enable, load, load_val, mode -> Q, TC, busy, done.
module cont4bits_down_timer #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             reseta_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned    MAX_I = MODULO - 1;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_I);

    generate
        if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
            $error("MODULO out of range for WIDTH");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] load_sat;

    // Out-of-range load values saturate so Q never exceeds MODULO-1.
    assign load_sat = (32'(load_val) > MAX_I) ? MAX : load_val;

    always_ff @(posedge clk) begin
        if (!reseta_n) begin
            state <= IDLE;
            q     <= MAX;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                q     <= load_sat;
                state <= RUN;
            end else if (enable && state != DONE) begin
                // IDLE starts counting on the same edge it leaves.
                state <= RUN;
                if (q != '0) begin
                    q <= q - 1'b1;
                end else if (!mode) begin
                    q <= MAX;
                end else begin
                    state <= DONE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign Q    = q;
    assign busy = (state == RUN);
    // Borrow-out is combinational on enable so a cascaded stage steps in the same cycle.
    assign TC   = (q == '0) && enable && (state != DONE);

endmodule

// File: tb/tb_cont4bits_down_timer.sv
// Directed self-checking bench for cont4bits_down_timer (WIDTH=4, MODULO=10).
// Drives inputs 1ns after the rising edge and samples outputs before the next edge.
module tb_cont4bits_down_timer;

    logic       clk = 1'b0;
    logic       reseta_n;
    logic       enable;
    logic       load;
    logic [3:0] load_val;
    logic       mode;
    logic [3:0] Q;
    logic       TC;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    cont4bits_down_timer #(
        .WIDTH (4),
        .MODULO(10)
    ) dut (
        .clk     (clk),
        .reseta_n(reseta_n),
        .enable  (enable),
        .load    (load),
        .load_val(load_val),
        .mode    (mode),
        .Q       (Q),
        .TC      (TC),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] cont_q [12];
    logic [3:0] mq;
    logic       en_r;

    initial begin
        cont_q = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3,
                   4'd2, 4'd1, 4'd0, 4'd9, 4'd8, 4'd7};
        reseta_n = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        mode     = 1'b0;

        // 1: reset state and hold
        tick();
        chk("rst_q", 32'(Q), 9);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tc", 32'(TC), 0);
        reseta_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_q", 32'(Q), 9);
        end

        // 2: continuous wrap
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("cont_tc", 32'(TC), (i == 9) ? 1 : 0);
            tick();
            chk("cont_q", 32'(Q), 32'(cont_q[i]));
            chk("cont_done", 32'(done), 0);
            chk("cont_busy", 32'(busy), 1);
        end
        enable = 1'b0;

        // 3: one-shot
        mode     = 1'b1;
        load     = 1'b1;
        load_val = 4'd3;
        tick();
        chk("os_load_q", 32'(Q), 3);
        chk("os_load_busy", 32'(busy), 1);
        load   = 1'b0;
        enable = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            chk("os_q", 32'(Q), 32'(i));
            chk("os_done0", 32'(done), 0);
        end
        #1;
        chk("os_tc_last", 32'(TC), 1);
        tick();
        chk("os_fin_q", 32'(Q), 0);
        chk("os_done1", 32'(done), 1);
        chk("os_fin_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("done_tc", 32'(TC), 0);
            tick();
            chk("done_q", 32'(Q), 0);
            chk("done_pulse", 32'(done), 0);
            chk("done_busy", 32'(busy), 0);
        end

        // 4: load from DONE, priority over enable, saturation
        load     = 1'b1;
        load_val = 4'd6;
        tick();
        chk("ld_done_q", 32'(Q), 6);
        chk("ld_done_busy", 32'(busy), 1);
        load_val = 4'd13;
        tick();
        chk("sat13_q", 32'(Q), 9);
        load_val = 4'd15;
        tick();
        chk("sat15_q", 32'(Q), 9);
        load_val = 4'd9;
        tick();
        chk("ld9_q", 32'(Q), 9);
        load_val = 4'd0;
        tick();
        chk("ld0_q", 32'(Q), 0);

        // 5: reset mid-count, glitch between edges ignored
        load_val = 4'd5;
        enable   = 1'b0;
        mode     = 1'b0;
        tick();
        load = 1'b0;
        chk("mid_q", 32'(Q), 5);
        reseta_n = 1'b0;
        #2;
        reseta_n = 1'b1;
        tick();
        chk("glitch_q", 32'(Q), 5);
        chk("glitch_busy", 32'(busy), 1);
        reseta_n = 1'b0;
        enable   = 1'b1;
        tick();
        chk("mrst_q", 32'(Q), 9);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        reseta_n = 1'b1;
        enable   = 1'b0;
        tick();
        chk("mrst_hold", 32'(Q), 9);

        // 6: random enable against a reference model
        mq = 4'd9;
        for (int i = 0; i < 30; i++) begin
            en_r   = 1'($urandom_range(0, 1));
            enable = en_r;
            #1;
            chk("rnd_tc", 32'(TC), 32'((mq == 4'd0) && en_r));
            if (en_r) mq = (mq == 4'd0) ? 4'd9 : mq - 4'd1;
            tick();
            chk("rnd_q", 32'(Q), 32'(mq));
        end
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
